// File: rtl/npu_pkg.sv
// Shared NPU definitions: output-memory widths, conv-engine widths and the reader FSM state type.
// Pure declarations, no logic.
package npu_pkg;

  localparam int NPU_ADDR_W = 16;
  localparam int NPU_DATA_W = 32;
  localparam int NPU_CNT_W  = 16;

  // Convolution engine widths used by the NPU top level
  localparam int CONV_PIX_W  = 8;
  localparam int CONV_WGT_W  = 8;
  localparam int CONV_ACC_W  = 32;
  localparam int CONV_KDIM_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/out_fifo2.sv
// Two-entry register FIFO, head visible combinationally from registers; push-to-head latency 1 cycle.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module out_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_ent0;
  logic [W-1:0] r_ent1;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_ent0 <= i_push_dat;
          else                 r_ent1 <= i_push_dat;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_ent0  <= r_ent1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_ent0 <= i_push_dat;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= i_push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head_dat = r_ent0;
  assign o_count    = r_count;

endmodule

// File: rtl/out_mem_reader.sv
// Drains a contiguous output-memory region into a valid/ready stream; first word 3 cycles after start.
// Reads are only issued when buffered + in-flight words leave room, so a stalled sink never loses data.
module out_mem_reader
  import npu_pkg::*;
#(
  parameter int ADDR_W = NPU_ADDR_W,
  parameter int DATA_W = NPU_DATA_W,
  parameter int CNT_W  = NPU_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_accepted;
  logic              r_inflight;
  logic              r_inf_last;

  logic              w_start_ok;
  logic              w_pop;
  logic              w_issue;
  logic              w_done;
  logic              w_all_issued;
  logic              w_last_issue;
  logic              w_drained;
  logic [1:0]        w_fifo_cnt;
  logic [1:0]        w_occ;
  logic [DATA_W:0]   w_head;

  assign w_start_ok   = (r_state == IDLE) && start;
  assign w_pop        = m_valid && m_ready;
  assign w_all_issued = (r_issued == r_count);
  assign w_last_issue = ((r_issued + CNT_W'(1)) == r_count);
  assign w_drained    = (r_accepted == r_count) && (w_fifo_cnt == 2'd0) && !r_inflight;
  // A word leaving this cycle frees its slot, which keeps the stream gap-free
  assign w_occ        = w_fifo_cnt + 2'(r_inflight) - 2'(w_pop);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = READ;
      READ:    if (w_all_issued || (w_issue && w_last_issue)) w_state_nxt = DRAIN;
      DRAIN:   if (w_drained) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_issue = 1'b0;
    w_done  = 1'b0;
    busy    = 1'b0;
    case (r_state)
      READ: begin
        w_issue = !w_all_issued && (w_occ < 2'd2);
        busy    = 1'b1;
      end
      DRAIN: begin
        w_done = w_drained;
        busy   = !w_drained;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base     <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_inflight <= 1'b0;
      r_inf_last <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_base     <= base_addr;
        r_count    <= word_count;
        r_issued   <= '0;
        r_accepted <= '0;
      end else begin
        if (w_issue) r_issued   <= r_issued + CNT_W'(1);
        if (w_pop)   r_accepted <= r_accepted + CNT_W'(1);
      end
      r_inflight <= w_issue;
      r_inf_last <= w_issue && w_last_issue;
    end
  end

  out_fifo2 #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (r_inflight),
    .i_push_dat ({r_inf_last, mem_dout}),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_fifo_cnt)
  );

  assign done     = w_done;
  assign mem_en   = w_issue;
  assign mem_we   = 1'b0;
  assign mem_addr = r_base + ADDR_W'(r_issued);
  assign m_valid  = (w_fifo_cnt != 2'd0);
  assign m_data   = w_head[DATA_W-1:0];
  assign m_last   = m_valid && w_head[DATA_W];

endmodule

// File: tb/tb_out_mem_reader.sv
// Directed bench for out_mem_reader: memory model returns 0x100 + address one cycle after mem_en.
module tb_out_mem_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_dout;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] q_addr[$];
  logic [31:0] q_dat[$];
  logic        q_last[$];
  int first_en, first_vld, last_vld, vld_cyc, done_cyc, n_done;
  int viol_out, viol_stall, en_after_done, n_lastflag;
  logic busy_c1, busy_at_done;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_dout <= 32'h100 + {16'h0, mem_addr};

  out_mem_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    return (cyc % 4 == 0) || (cyc % 4 == 3);
  endfunction

  // Cycle 0 carries the start pulse; cycle k is k clock edges later.
  task automatic xfer(input logic [15:0] base, input logic [15:0] cnt, input int rmode,
                      input int inj_cyc, input int tail, input int max_cyc);
    int cyc, n_iss, n_acc, tail_left, hs;
    bit prev_stall, seen_done;
    logic [32:0] prev_word;
    q_addr.delete(); q_dat.delete(); q_last.delete();
    first_en = -1; first_vld = -1; last_vld = -1; vld_cyc = 0; done_cyc = -1; n_done = 0;
    viol_out = 0; viol_stall = 0; en_after_done = 0; n_lastflag = 0;
    busy_c1 = 1'b0; busy_at_done = 1'bx;
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = cnt; m_ready = rdy(rmode, 0);
    cyc = 0; n_iss = 0; n_acc = 0; prev_stall = 0; seen_done = 0; tail_left = tail;
    prev_word = '0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      start = (cyc == inj_cyc);
      if (start) begin
        base_addr = 16'h0050; word_count = 16'd2;
      end
      m_ready = rdy(rmode, cyc);
      #1;
      if (cyc == 1) busy_c1 = busy;
      hs = (m_valid && m_ready) ? 1 : 0;
      if (mem_en) begin
        if (n_iss - n_acc - hs >= 2) viol_out++;
        if (seen_done) en_after_done++;
        else begin
          q_addr.push_back(mem_addr);
          if (first_en < 0) first_en = cyc;
        end
        n_iss++;
      end
      if (prev_stall && (!m_valid || {m_last, m_data} != prev_word)) viol_stall++;
      if (m_valid) begin
        vld_cyc++;
        if (first_vld < 0) first_vld = cyc;
        last_vld = cyc;
      end
      if (hs == 1) begin
        q_dat.push_back(m_data); q_last.push_back(m_last); n_acc++;
        if (m_last) n_lastflag++;
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc; busy_at_done = busy;
        end
        seen_done = 1;
      end
      if (seen_done) begin
        if (tail_left == 0) break;
        tail_left--;
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_words(input string tag, input logic [15:0] base, input int cnt);
    logic [15:0] a;
    chk({tag, "_naddr"}, q_addr.size(), cnt);
    chk({tag, "_nword"}, q_dat.size(), cnt);
    for (int i = 0; i < cnt; i++) begin
      a = base + 16'(i);
      if (i < q_addr.size()) chk($sformatf("%s_addr%0d", tag, i), q_addr[i], a);
      if (i < q_dat.size()) begin
        chk($sformatf("%s_dat%0d", tag, i), q_dat[i], 32'h100 + {16'h0, a});
        chk($sformatf("%s_last%0d", tag, i), q_last[i], (i == cnt - 1));
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", {busy, done, mem_en, mem_we, mem_addr, m_valid, m_data, m_last}, '0);
    reset = 1'b0;
    @(negedge clk);

    // Basic burst, sink always ready
    xfer(16'h0000, 16'd16, 0, -1, 0, 100);
    chk("t1_first_en", first_en, 1);
    chk("t1_first_vld", first_vld, 3);
    chk("t1_last_vld", last_vld, 18);
    chk("t1_vld_cyc", vld_cyc, 16);
    chk("t1_done_cyc", done_cyc, 19);
    chk("t1_busy_c1", busy_c1, 1'b1);
    chk("t1_busy_done", busy_at_done, 1'b0);
    chk("t1_nlast", n_lastflag, 1);
    chk_words("t1", 16'h0000, 16);

    // Started in the cycle right after done; sink toggles 1,0,0,1
    xfer(16'h0000, 16'd8, 1, -1, 0, 200);
    chk("t2_first_en", first_en, 1);
    chk("t2_viol_out", viol_out, 0);
    chk("t2_viol_stall", viol_stall, 0);
    chk("t2_ndone", n_done, 1);
    chk_words("t2", 16'h0000, 8);

    // Address wrap
    xfer(16'hFFFE, 16'd4, 0, -1, 0, 100);
    chk_words("t3", 16'hFFFE, 4);
    chk("t3_done_cyc", done_cyc, 7);

    // Empty transfer
    xfer(16'h0010, 16'd0, 0, -1, 2, 50);
    chk("t4_done_cyc", done_cyc, 2);
    chk("t4_nen", q_addr.size() + en_after_done, 0);
    chk("t4_vld_cyc", vld_cyc, 0);
    chk("t4_ndone", n_done, 1);

    // Reset mid-transfer
    @(negedge clk);
    start = 1'b1; base_addr = 16'h0200; word_count = 16'd1000; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("t5_busy_pre", busy, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_rst_outs", {busy, done, mem_en, mem_we, mem_addr, m_valid, m_data, m_last}, '0);
    xfer(16'h0000, 16'd4, 0, -1, 0, 100);
    chk_words("t5", 16'h0000, 4);
    chk("t5_first_vld", first_vld, 3);

    // Start while busy is ignored
    xfer(16'h0020, 16'd6, 0, 4, 3, 100);
    chk_words("t6a", 16'h0020, 6);
    chk("t6a_ndone", n_done, 1);
    chk("t6a_en_after", en_after_done, 0);

    // Start coinciding with done is ignored
    xfer(16'h0030, 16'd6, 0, 9, 3, 100);
    chk("t6b_done_cyc", done_cyc, 9);
    chk_words("t6b", 16'h0030, 6);
    chk("t6b_ndone", n_done, 1);
    chk("t6b_en_after", en_after_done, 0);
    #1;
    chk("t6b_idle_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
